// File: rtl/feed_fifo_pkg.sv
// Shared constants and helpers for the feed_fifo elastic input stage.
package feed_fifo_pkg;

  localparam int unsigned UNDERRUN_W = 16;
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  // Pointer width for a given depth: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/feed_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
// No reset; contents are don't-care until written.
module feed_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on a write strobe.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/feed_fifo.sv
// Elastic input stage ahead of the delay pipeline: buffers producer words and
// presents one word per advance cycle on a registered output, inserting a zero
// bubble and counting the underrun when the buffer is empty.
module feed_fifo
  import feed_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  m_en,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  output logic [AW:0]           count,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  typedef logic [ptr_width(DEPTH)-1:0] ptr_t;

  ptr_t                  wr_q, wr_d;
  ptr_t                  rd_q, rd_d;
  logic [WIDTH-1:0]      m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  logic             empty;
  logic             full;
  logic             push;
  logic [WIDTH-1:0] rd_word;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign s_ready = !full && !reset;
  assign push    = s_valid && s_ready;

  feed_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_q[AW-1:0]),
    .wdata(s_data),
    .raddr(rd_q[AW-1:0]),
    .rdata(rd_word)
  );

  // Next-state: write pointer on push; output register, read pointer and
  // underrun counter only move on an advance strobe.
  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    underrun_d = underrun_q;
    if (push) wr_d = wr_q + 1'b1;
    if (m_en) begin
      if (!empty) begin
        m_data_d  = rd_word;
        m_valid_d = 1'b1;
        rd_d      = rd_q + 1'b1;
      end else begin
        m_data_d  = '0;
        m_valid_d = 1'b0;
        if (underrun_q != UNDERRUN_MAX) underrun_d = underrun_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign count        = wr_q - rd_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_feed_fifo.sv
// Directed self-checking bench for feed_fifo (WIDTH=8, DEPTH=4).
module tb_feed_fifo;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic [2:0]  count;
  logic [15:0] underrun_cnt;

  int vectors;
  int miscompares;

  feed_fifo #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_en        (m_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .count       (count),
    .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 8'hAA; m_en = 1'b0;
    repeat (3) step();
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    vectors++; if (m_data !== 8'h00) begin miscompares++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (underrun_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_underrun got=%h exp=0000", underrun_cnt); end
    reset = 1'b0; s_valid = 1'b0;
    step();
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_ordering();
    logic [7:0] exp_d [4];
    logic       exp_v [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h00};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
    s_valid = 1'b1;
    s_data = 8'h11; step();
    s_data = 8'h22; step();
    s_data = 8'h33; step();
    s_valid = 1'b0;
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL order_count got=%0d exp=3", count); end
    m_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (m_data !== exp_d[i]) begin miscompares++; $display("FAIL order_data[%0d] got=%h exp=%h", i, m_data, exp_d[i]); end
      vectors++; if (m_valid !== exp_v[i]) begin miscompares++; $display("FAIL order_valid[%0d] got=%b exp=%b", i, m_valid, exp_v[i]); end
    end
    m_en = 1'b0;
    vectors++; if (underrun_cnt !== 16'd1) begin miscompares++; $display("FAIL order_underrun got=%0d exp=1", underrun_cnt); end
  endtask

  task automatic test_full();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'hA0 + 8'(i);
      vectors++; if (s_ready !== (i < 4)) begin miscompares++; $display("FAIL full_s_ready[%0d] got=%b exp=%b", i, s_ready, (i < 4)); end
      step();
    end
    s_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", count); end
    m_en = 1'b1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_with_m_en got=%b exp=0", s_ready); end
    step();
    m_en = 1'b0;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_pop got=%b exp=1", s_ready); end
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL full_count_after_pop got=%0d exp=3", count); end
    vectors++; if (m_data !== 8'hA0) begin miscompares++; $display("FAIL full_first_out got=%h exp=a0", m_data); end
    m_en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      vectors++; if (m_data !== 8'hA0 + 8'(i)) begin miscompares++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, m_data, 8'hA0 + 8'(i)); end
    end
    m_en = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL full_drained_count got=%0d exp=0", count); end
  endtask

  task automatic test_streaming();
    s_valid = 1'b1; m_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      s_data = 8'(k);
      step();
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
      if (k == 1) begin
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first_bubble got=%b exp=0", m_valid); end
      end else begin
        vectors++; if (m_valid !== 1'b1 || m_data !== 8'(k - 1)) begin
          miscompares++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", k, m_valid, m_data, 8'(k - 1));
        end
      end
    end
    s_valid = 1'b0;
    step();
    m_en = 1'b0;
    vectors++; if (m_data !== 8'd20 || count !== 3'd0) begin miscompares++; $display("FAIL stream_tail got=%h/%0d exp=14/0", m_data, count); end
    vectors++; if (underrun_cnt !== 16'd2) begin miscompares++; $display("FAIL stream_underrun got=%0d exp=2", underrun_cnt); end
  endtask

  task automatic test_wrap_saturation();
    s_valid = 1'b1; m_en = 1'b0;
    s_data = 8'h40; step();
    s_data = 8'h41; step();
    m_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_data = 8'h42 + 8'(i);
      step();
      vectors++; if (m_data !== 8'h40 + 8'(i) || count !== 3'd2) begin
        miscompares++; $display("FAIL wrap[%0d] got=%h/%0d exp=%h/2", i, m_data, count, 8'h40 + 8'(i));
      end
    end
    s_valid = 1'b0;
    step();
    vectors++; if (m_data !== 8'h4C) begin miscompares++; $display("FAIL wrap_tail0 got=%h exp=4c", m_data); end
    step();
    vectors++; if (m_data !== 8'h4D || count !== 3'd0) begin miscompares++; $display("FAIL wrap_tail1 got=%h/%0d exp=4d/0", m_data, count); end
    m_en = 1'b0;
    reset = 1'b1; step(); reset = 1'b0; step();
    m_en = 1'b1;
    repeat (65534) step();
    vectors++; if (underrun_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_near got=%h exp=fffe", underrun_cnt); end
    step();
    vectors++; if (underrun_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got=%h exp=ffff", underrun_cnt); end
    repeat (2) step();
    vectors++; if (underrun_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%h exp=ffff", underrun_cnt); end
    m_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    s_valid = 1'b1; m_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'h61 + 8'(i);
      step();
    end
    s_valid = 1'b0; m_en = 1'b1;
    step();
    m_en = 1'b0;
    vectors++; if (m_data !== 8'h61 || count !== 3'd3) begin miscompares++; $display("FAIL mid_pre got=%h/%0d exp=61/3", m_data, count); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (m_data !== 8'h00 || m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_out got=%h/%b exp=00/0", m_data, m_valid); end
    vectors++; if (count !== 3'd0 || s_ready !== 1'b0) begin miscompares++; $display("FAIL mid_async_count got=%0d/%b exp=0/0", count, s_ready); end
    step();
    reset = 1'b0;
    m_en = 1'b1;
    step();
    m_en = 1'b0;
    vectors++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin miscompares++; $display("FAIL mid_bubble got=%b/%h exp=0/00", m_valid, m_data); end
    vectors++; if (underrun_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_underrun got=%0d exp=1", underrun_cnt); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_en = 1'b0;
    #1;
    test_reset();
    test_ordering();
    test_full();
    test_streaming();
    test_wrap_saturation();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
